// File: rtl/axonerve_wordcount_axi_slave_mem.sv
// AXI4 INCR-burst responder memory with independent read and write engines.
// Optional protocol checker: AXONERVE_WORDCOUNT_AXI_SLAVE_ERRCHK_EN drives a sticky prot_err.
module axonerve_wordcount_axi_slave_mem #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 512,
  parameter int unsigned C_MEM_DEPTH_LOG2   = 10
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wlast,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic                              s_axi_rlast,
  output logic                              prot_err
);

  localparam int unsigned NB    = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(NB);
  localparam int unsigned IW    = C_MEM_DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << IW;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [1:0]    r_wstate, w_wstate_nxt;
  logic          r_awready, r_wready, r_bvalid;
  logic [7:0]    r_awlen, r_wcnt;
  logic [IW-1:0] r_widx;
  logic          w_aw_hs, w_w_hs, w_wcnt_last;
  logic [IW-1:0] w_aw_idx;

  logic [0:0]    r_rstate, w_rstate_nxt;
  logic          r_arready, r_rvalid, r_rlast;
  logic [7:0]    r_arlen, r_rcnt;
  logic [IW-1:0] r_ridx;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic          w_ar_hs, w_r_hs;
  logic [IW-1:0] w_ar_idx;

  assign w_aw_idx    = s_axi_awaddr[LSB +: IW];
  assign w_ar_idx    = s_axi_araddr[LSB +: IW];
  assign w_aw_hs     = r_awready & s_axi_awvalid;
  assign w_w_hs      = r_wready & s_axi_wvalid;
  assign w_ar_hs     = r_arready & s_axi_arvalid;
  assign w_r_hs      = r_rvalid & s_axi_rready;
  assign w_wcnt_last = (r_wcnt == r_awlen);

  // Write next-state: the beat count, not wlast, closes the burst.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (s_axi_awvalid)                   w_wstate_nxt = W_DATA;
      W_DATA:  if (s_axi_wvalid && w_wcnt_last)     w_wstate_nxt = W_RESP;
      W_RESP:  if (s_axi_bready)                    w_wstate_nxt = W_IDLE;
      default:                                      w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_awlen   <= '0;
      r_wcnt    <= '0;
      r_widx    <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_aw_hs) begin
        r_widx  <= w_aw_idx;
        r_awlen <= s_axi_awlen;
        r_wcnt  <= '0;
      end else if (w_w_hs) begin
        r_widx  <= r_widx + IW'(1);
        r_wcnt  <= r_wcnt + 8'(1);
      end
    end
  end

  // Byte-enabled storage; contents survive reset.
  always_ff @(posedge ap_clk) begin
    if (w_w_hs) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b]) r_mem[r_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (s_axi_arvalid)                w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi_rready && r_rlast)      w_rstate_nxt = R_IDLE;
      default:                                   w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read beat register: loaded on address accept and on each non-final handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_arlen   <= '0;
      r_rcnt    <= '0;
      r_ridx    <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs) begin
        r_rdata <= r_mem[w_ar_idx];
        r_ridx  <= w_ar_idx + IW'(1);
        r_arlen <= s_axi_arlen;
        r_rcnt  <= '0;
        r_rlast <= (s_axi_arlen == 8'd0);
      end else if (w_r_hs) begin
        if (r_rlast) begin
          r_rlast <= 1'b0;
        end else begin
          r_rdata <= r_mem[r_ridx];
          r_ridx  <= r_ridx + IW'(1);
          r_rcnt  <= r_rcnt + 8'(1);
          r_rlast <= ((r_rcnt + 8'(1)) == r_arlen);
        end
      end
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rlast   = r_rlast;

`ifdef AXONERVE_WORDCOUNT_AXI_SLAVE_ERRCHK_EN
  logic r_prot_err;
  logic w_aw_oob, w_ar_oob, w_wlast_bad;

  assign w_aw_oob    = (s_axi_awaddr >> (LSB + IW)) != '0;
  assign w_ar_oob    = (s_axi_araddr >> (LSB + IW)) != '0;
  assign w_wlast_bad = (s_axi_wlast != w_wcnt_last);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_prot_err <= 1'b0;
    end else if ((w_aw_hs && w_aw_oob) || (w_ar_hs && w_ar_oob) || (w_w_hs && w_wlast_bad)) begin
      r_prot_err <= 1'b1;
    end
  end

  assign prot_err = r_prot_err;
`else
  assign prot_err = 1'b0;
`endif

  // Address bits outside the word index and wlast are don't-cares to the data path.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, s_axi_awaddr, s_axi_araddr, s_axi_wlast};

endmodule

// File: tb/tb_axonerve_wordcount_axi_slave_mem.sv
// Scoreboard bench: stimulus pushes expected read beats, an R-channel monitor pops and compares.
module tb_axonerve_wordcount_axi_slave_mem;

  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 512;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 1024;
  localparam int          TMO   = 200;
`ifdef AXONERVE_WORDCOUNT_AXI_SLAVE_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast, prot_err;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [DW-1:0] wdata, rdata;
  logic [NB-1:0] wstrb;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         q[$];
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] wbuf_d [256];
  logic [NB-1:0] wbuf_s [256];
  int            n_checks = 0;
  int            n_fail = 0;
  int            rmode = 0;

  axonerve_wordcount_axi_slave_mem dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
    .prot_err(prot_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0b exp=%0b", nm, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NB-1:0] rnd_strb();
    logic [NB-1:0] v;
    for (int i = 0; i < NB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a[6 +: 10]);
  endfunction

  // wlast_at < 0 means a well-formed burst; bhold cycles of bready=0 before accepting B.
  task automatic wr_burst(input logic [AW-1:0] addr, input int len, input int wlast_at, input int bhold);
    int idx;
    int t;
    idx = idx_of(addr);
    @(negedge clk);
    awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
    t = 0;
    while (!awready && t < TMO) begin @(negedge clk); t++; end
    chk1("aw_timeout", t < TMO, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if ($urandom_range(3) == 0) begin wvalid = 1'b0; @(negedge clk); end
      wvalid = 1'b1; wdata = wbuf_d[k]; wstrb = wbuf_s[k];
      wlast  = (wlast_at < 0) ? (k == len) : (k == wlast_at);
      t = 0;
      while (!wready && t < TMO) begin @(negedge clk); t++; end
      chk1("w_timeout", t < TMO, 1'b1);
      chk1("bvalid_early", bvalid, 1'b0);
      for (int b = 0; b < NB; b++)
        if (wbuf_s[k][b]) m_mem[(idx + k) % DEPTH][b*8 +: 8] = wbuf_d[k][b*8 +: 8];
      @(negedge clk);
      if (wlast_at >= 0 && k == wlast_at && wlast_at != len) chk1("prot_err_wlast", prot_err, ERRCHK);
    end
    wvalid = 1'b0; wlast = 1'b0;
    t = 0;
    while (!bvalid && t < TMO) begin @(negedge clk); t++; end
    chk1("b_timeout", t < TMO, 1'b1);
    chk1("awready_in_resp", awready, 1'b0);
    for (int i = 0; i < bhold; i++) begin
      @(negedge clk);
      chk1("bvalid_hold", bvalid, 1'b1);
      chk1("awready_hold", awready, 1'b0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk1("bvalid_clear", bvalid, 1'b0);
    chk1("awready_back", awready, 1'b1);
  endtask

  task automatic ar_issue(input logic [AW-1:0] addr, input int len);
    int t;
    @(negedge clk);
    arvalid = 1'b1; araddr = addr; arlen = 8'(len);
    t = 0;
    while (!arready && t < TMO) begin @(negedge clk); t++; end
    chk1("ar_timeout", t < TMO, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
    chk1("rvalid_first", rvalid, 1'b1);
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input int len);
    int idx;
    int t;
    idx = idx_of(addr);
    for (int k = 0; k <= len; k++) q.push_back('{d: m_mem[(idx + k) % DEPTH], l: (k == len)});
    ar_issue(addr, len);
    t = 0;
    while (q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    chk1("r_timeout", t < 2000, 1'b1);
    @(negedge clk);
    chk1("arready_after", arready, 1'b1);
    chk1("rvalid_after", rvalid, 1'b0);
  endtask

  // R-channel monitor: drives rready per rmode, checks hold-while-stalled and scoreboard order.
  initial begin
    bit            held;
    logic [DW-1:0] hd;
    logic          hl;
    int            tog;
    beat_t         e;
    held = 1'b0; tog = 0; rready = 1'b0;
    forever begin
      @(negedge clk);
      if (held && rvalid) begin
        chk("rdata_hold", rdata, hd);
        chk1("rlast_hold", rlast, hl);
      end
      case (rmode)
        0:       rready = 1'b1;
        1:       begin rready = (tog % 2 == 0); tog++; end
        2:       rready = 1'($urandom_range(1));
        default: rready = 1'b0;
      endcase
      held = 1'b0;
      if (rvalid && rready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rbeat got=%0h exp=none", rdata);
        end else begin
          e = q.pop_front();
          chk("rdata", rdata, e.d);
          chk1("rlast", rlast, e.l);
        end
      end else if (rvalid) begin
        held = 1'b1; hd = rdata; hl = rlast;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    int            len;
    awvalid = 0; awaddr = '0; awlen = '0; wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 0;
    arvalid = 0; araddr = '0; arlen = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk1("rst_awready", awready, 1'b1);
    chk1("rst_arready", arready, 1'b1);
    chk1("rst_wready", wready, 1'b0);
    chk1("rst_bvalid", bvalid, 1'b0);
    chk1("rst_rvalid", rvalid, 1'b0);
    chk1("rst_rlast", rlast, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk1("rst_prot_err", prot_err, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // zero the whole array so every later read has a known reference
    for (int k = 0; k < 256; k++) begin wbuf_d[k] = '0; wbuf_s[k] = '1; end
    for (int s = 0; s < 4; s++) wr_burst(AW'(s * 256 * 64), 255, -1, 0);

    for (int k = 0; k < 4; k++) begin wbuf_d[k] = DW'(k + 1); wbuf_s[k] = '1; end
    wr_burst(AW'(0), 3, -1, 0);
    rd_burst(AW'(0), 3);

    wbuf_d[0] = rnd_data(); wbuf_d[0][7:0] = 8'hAB; wbuf_s[0] = NB'(1);
    wr_burst(AW'('h40), 0, -1, 0);
    rd_burst(AW'('h40), 0);

    for (int k = 0; k < 2; k++) begin wbuf_d[k] = rnd_data(); wbuf_s[k] = '1; end
    wr_burst(AW'('hFFC0), 1, -1, 0);
    rd_burst(AW'(0), 0);
    rd_burst(AW'('hFFC0), 1);

    for (int k = 0; k < 8; k++) begin wbuf_d[k] = rnd_data(); wbuf_s[k] = '1; end
    wr_burst(AW'('h2000), 7, -1, 5);
    rmode = 1;
    rd_burst(AW'('h2000), 7);
    rmode = 0;

    for (int it = 0; it < 20; it++) begin
      a   = AW'($urandom_range(DEPTH - 1)) * 64 + AW'($urandom_range(63));
      len = int'($urandom_range(15));
      for (int k = 0; k <= len; k++) begin
        wbuf_d[k] = rnd_data();
        wbuf_s[k] = ($urandom_range(1) == 0) ? '1 : rnd_strb();
      end
      wr_burst(a, len, -1, int'($urandom_range(2)));
      rmode = 2;
      rd_burst(a - AW'(64 * $urandom_range(3)), int'($urandom_range(15)));
      rmode = 0;
    end

    chk1("prot_err_before", prot_err, 1'b0);
    for (int k = 0; k < 4; k++) begin wbuf_d[k] = rnd_data(); wbuf_s[k] = '1; end
    wr_burst(AW'('h400), 3, 1, 0);
    chk1("prot_err_after", prot_err, ERRCHK);
    rd_burst(AW'('h400), 3);

    wbuf_d[0] = rnd_data(); wbuf_s[0] = '1;
    wr_burst(AW'('h1_0080), 0, -1, 0);
    rd_burst(AW'('h80), 0);
    chk1("prot_err_highaddr", prot_err, ERRCHK);

    rmode = 3;
    ar_issue(AW'(0), 15);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_rvalid", rvalid, 1'b0);
    chk1("mid_rst_arready", arready, 1'b1);
    chk1("mid_rst_rlast", rlast, 1'b0);
    chk1("mid_rst_prot_err", prot_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    rmode = 0;
    @(negedge clk);
    rd_burst(AW'(0), 3);
    rd_burst(AW'('hFFC0), 1);

    repeat (4) @(negedge clk);
    chk1("scoreboard_empty", q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
